hs_npu_memory_responder: RTL and testbench

Memory-side responder for the NPU memory ordering unit's read/write handshake. It accepts one beat (BURST_SIZE 32-bit words) per request. Each beat is split into sequential word accesses on a single-port, fixed-latency, word-addressed SRAM. Read words are gathered and returned as a single-cycle `mem_valid_o` beat; write words are committed before the next request is accepted. It sits between `hs_npu` and the on-chip scratchpad.

---
 rtl/hs_npu_pkg.sv | 17 +
 rtl/hs_npu_memory_responder_if.sv | 40 ++++
 rtl/hs_npu_latency_pipe.sv | 41 ++++
 rtl/hs_npu_memory_responder.sv | 163 ++++++++++++++++
 tb/tb_hs_npu_memory_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_npu_pkg.sv
// Shared types for the hs_npu memory responder slice.
// Word type, responder FSM encoding and byte/word constants.
package hs_npu_pkg;

  typedef logic [31:0] uword;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_ISSUE
  } mem_resp_state_t;

endpackage

// File: rtl/hs_npu_memory_responder_if.sv
// Initiator-side read/write beat handshake of the memory responder.
// master = hs_npu initiator, slave = responder.
interface hs_npu_memory_responder_if
  import hs_npu_pkg::*;
#(
  parameter int BURST_SIZE = 2
) ();

  logic mem_read_ready_i;
  logic mem_write_valid_i;
  logic mem_invalidate_i;
  uword request_address_i;
  uword write_data_i [BURST_SIZE];
  logic mem_valid_o;
  logic mem_ready_o;
  uword read_data_o [BURST_SIZE];

  modport master (
    output mem_read_ready_i,
    output mem_write_valid_i,
    output mem_invalidate_i,
    output request_address_i,
    output write_data_i,
    input  mem_valid_o,
    input  mem_ready_o,
    input  read_data_o
  );

  modport slave (
    input  mem_read_ready_i,
    input  mem_write_valid_i,
    input  mem_invalidate_i,
    input  request_address_i,
    input  write_data_i,
    output mem_valid_o,
    output mem_ready_o,
    output read_data_o
  );

endinterface

// File: rtl/hs_npu_latency_pipe.sv
// Valid+index shift register tagging fixed-latency SRAM returns.
// A synchronous flush drops every tag in flight.
module hs_npu_latency_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        idx_q[i] <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        idx_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/hs_npu_memory_responder.sv
// Memory-side responder: splits each beat into word accesses on a
// single-port fixed-latency SRAM and returns reads as one pulse.
module hs_npu_memory_responder
  import hs_npu_pkg::*;
#(
  parameter int BURST_SIZE   = 2,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hs_npu_memory_responder_if.slave bus,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output uword                  sram_wdata_o,
  input  uword                  sram_rdata_i
);

  localparam int IDX_W = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  localparam int LSB   = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BURST_SIZE - 1);

  mem_resp_state_t       state_q;
  logic                  valid_q;
  logic                  ready_q;
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] base_q;
  uword                  wdata_q;
  uword                  rdata_q [BURST_SIZE];
  uword                  wbuf_q  [BURST_SIZE];
  logic [IDX_W-1:0]      idx_q;

  logic                  pv;
  logic [IDX_W-1:0]      pidx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [ADDR_WIDTH-1:0] base_in;
  logic                  rd_abort;
  logic                  unused_addr;

  assign base_in = bus.request_address_i[ADDR_WIDTH+LSB-1:LSB];
  assign unused_addr = ^{bus.request_address_i[31:ADDR_WIDTH+LSB],
                         bus.request_address_i[LSB-1:0]};
  assign idx_nxt = idx_q + 1'b1;
  assign rd_abort = bus.mem_invalidate_i &&
    (state_q inside {S_RD_ISSUE, S_RD_WAIT, S_RD_RESP});

  hs_npu_latency_pipe #(
    .DEPTH (READ_LATENCY),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (rd_abort),
    .valid_i (req_q & ~we_q),
    .idx_i   (idx_q),
    .valid_o (pv),
    .idx_o   (pidx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      for (int i = 0; i < BURST_SIZE; i++) begin
        rdata_q[i] <= '0;
        wbuf_q[i]  <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      // words returning into an aborted read are dropped
      if (pv && !rd_abort)
        rdata_q[pidx] <= sram_rdata_i;
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (bus.mem_invalidate_i) begin
            state_q <= S_IDLE;
          end else if (bus.mem_write_valid_i) begin
            state_q <= S_WR_ISSUE;
            ready_q <= 1'b0;
            base_q  <= base_in;
            addr_q  <= base_in;
            wbuf_q  <= bus.write_data_i;
            wdata_q <= bus.write_data_i[0];
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            idx_q   <= '0;
          end else if (bus.mem_read_ready_i) begin
            state_q <= S_RD_ISSUE;
            ready_q <= 1'b0;
            base_q  <= base_in;
            addr_q  <= base_in;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            idx_q   <= '0;
          end
        end
        S_RD_ISSUE: begin
          if (rd_abort) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            ready_q <= 1'b1;
          end else if (idx_q == LAST) begin
            state_q <= S_RD_WAIT;
            req_q   <= 1'b0;
          end else begin
            idx_q  <= idx_nxt;
            addr_q <= base_q + ADDR_WIDTH'(idx_nxt);
          end
        end
        S_RD_WAIT: begin
          if (rd_abort) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else if (pv && pidx == LAST) begin
            state_q <= S_RD_RESP;
            valid_q <= 1'b1;
          end
        end
        S_RD_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        S_WR_ISSUE: begin
          if (idx_q == LAST) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            idx_q   <= idx_nxt;
            addr_q  <= base_q + ADDR_WIDTH'(idx_nxt);
            wdata_q <= wbuf_q[idx_nxt];
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_valid_o = valid_q;
  assign bus.mem_ready_o = ready_q;
  assign bus.read_data_o = rdata_q;
  assign sram_req_o      = req_q;
  assign sram_we_o       = we_q;
  assign sram_addr_o     = addr_q;
  assign sram_wdata_o    = wdata_q;

endmodule

// File: tb/tb_hs_npu_memory_responder.sv
// Directed bench: two responders (latency 1 and 3) on SRAM models,
// read beats checked against a scoreboard of expected data and cycle.
module tb_hs_npu_memory_responder;
  import hs_npu_pkg::*;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1;
  exp_t e3;

  logic        req1, we1, req3, we3;
  logic [11:0] addr1, addr3;
  uword        wd1, wd3, rd1, rd3;
  uword        r3 [3];
  logic [31:0] mem1 [4096];
  logic [31:0] mem3 [4096];

  hs_npu_memory_responder_if #(.BURST_SIZE(2)) if1 ();
  hs_npu_memory_responder_if #(.BURST_SIZE(2)) if3 ();

  hs_npu_memory_responder #(
    .BURST_SIZE(2), .ADDR_WIDTH(12), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .sram_req_o(req1), .sram_we_o(we1), .sram_addr_o(addr1),
    .sram_wdata_o(wd1), .sram_rdata_i(rd1)
  );

  hs_npu_memory_responder #(
    .BURST_SIZE(2), .ADDR_WIDTH(12), .READ_LATENCY(3)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3),
    .sram_req_o(req3), .sram_we_o(we3), .sram_addr_o(addr3),
    .sram_wdata_o(wd3), .sram_rdata_i(rd3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: latency 1 and latency 3
  always @(posedge clk) begin
    if (req1 && we1) mem1[addr1] <= wd1;
    if (req1 && !we1) rd1 <= mem1[addr1];
    if (req3 && we3) mem3[addr3] <= wd3;
    if (req3 && !we3) r3[0] <= mem3[addr3];
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign rd3 = r3[2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(int which);
    for (int i = 0; i < 60; i++) begin
      if ((which == 1 ? q1.size() : q3.size()) == 0) break;
      tick(1);
    end
    check(which == 1 ? "drain1" : "drain3",
          which == 1 ? q1.size() : q3.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && if1.mem_valid_o === 1'b1) begin
      if (q1.size() == 0) begin
        check("valid1_unexpected", 1, 0);
      end else begin
        e1 = q1.pop_front();
        check("rd1_w0", if1.read_data_o[0], e1.d0);
        check("rd1_w1", if1.read_data_o[1], e1.d1);
        check("rd1_cycle", cyc, e1.cyc);
      end
    end
    if (rst_n && if3.mem_valid_o === 1'b1) begin
      if (q3.size() == 0) begin
        check("valid3_unexpected", 1, 0);
      end else begin
        e3 = q3.pop_front();
        check("rd3_w0", if3.read_data_o[0], e3.d0);
        check("rd3_w1", if3.read_data_o[1], e3.d1);
        check("rd3_cycle", cyc, e3.cyc);
      end
    end
  end

  initial begin
    if1.mem_read_ready_i = 0; if1.mem_write_valid_i = 0;
    if1.mem_invalidate_i = 0; if1.request_address_i = 0;
    if1.write_data_i[0] = 0; if1.write_data_i[1] = 0;
    if3.mem_read_ready_i = 0; if3.mem_write_valid_i = 0;
    if3.mem_invalidate_i = 0; if3.request_address_i = 0;
    if3.write_data_i[0] = 0; if3.write_data_i[1] = 0;

    // reset state
    tick(3);
    check("rst_ready", if1.mem_ready_o, 0);
    check("rst_valid", if1.mem_valid_o, 0);
    check("rst_req", req1, 0);
    check("rst_we", we1, 0);
    check("rst_addr", addr1, 0);
    check("rst_rd3_w0", if3.read_data_o[0], 0);
    rst_n = 1;
    tick(1);
    check("ready1_after_rst", if1.mem_ready_o, 1);
    check("ready3_after_rst", if3.mem_ready_o, 1);

    // latency 3: three back-to-back beats, 7 cycles apart
    for (int i = 0; i < 6; i++) mem3[i] <= 32'h100 + i;
    tick(1);
    t = cyc;
    if3.request_address_i = 32'h0;
    if3.mem_read_ready_i = 1;
    q3.push_back('{32'h100, 32'h101, t + 6});
    q3.push_back('{32'h102, 32'h103, t + 13});
    q3.push_back('{32'h104, 32'h105, t + 20});
    tick(6);
    if3.request_address_i = 32'h8;
    tick(7);
    if3.request_address_i = 32'h10;
    tick(7);
    if3.mem_read_ready_i = 0;
    drain(3);

    // basic read at 0x10
    mem1[4] <= 32'hA;
    mem1[5] <= 32'hB;
    tick(1);
    t = cyc;
    if1.request_address_i = 32'h10;
    if1.mem_read_ready_i = 1;
    q1.push_back('{32'hA, 32'hB, t + 4});
    tick(1);
    if1.mem_read_ready_i = 0;
    check("rd_req_t1", req1, 1);
    check("rd_we_t1", we1, 0);
    check("rd_addr_t1", addr1, 12'h004);
    tick(1);
    check("rd_req_t2", req1, 1);
    check("rd_addr_t2", addr1, 12'h005);
    tick(1);
    check("rd_req_t3", req1, 0);
    drain(1);

    // write {0x11,0x22} at 0x20
    tick(1);
    if1.request_address_i = 32'h20;
    if1.write_data_i[0] = 32'h11;
    if1.write_data_i[1] = 32'h22;
    if1.mem_write_valid_i = 1;
    tick(1);
    if1.mem_write_valid_i = 0;
    check("wr_ready_t1", if1.mem_ready_o, 0);
    check("wr_we_t1", we1, 1);
    check("wr_addr_t1", addr1, 12'h008);
    check("wr_data_t1", wd1, 32'h11);
    tick(1);
    check("wr_ready_t2", if1.mem_ready_o, 0);
    check("wr_we_t2", we1, 1);
    check("wr_addr_t2", addr1, 12'h009);
    check("wr_data_t2", wd1, 32'h22);
    tick(1);
    check("wr_ready_t3", if1.mem_ready_o, 1);
    check("wr_req_t3", req1, 0);
    check("sram_w8", mem1[8], 32'h11);
    check("sram_w9", mem1[9], 32'h22);

    // invalidate at t+2, then a fresh read
    mem1[16] <= 32'hC;
    mem1[17] <= 32'hD;
    tick(1);
    if1.request_address_i = 32'h40;
    if1.mem_read_ready_i = 1;
    tick(1);
    if1.mem_read_ready_i = 0;
    tick(1);
    if1.mem_invalidate_i = 1;
    tick(1);
    if1.mem_invalidate_i = 0;
    check("inv_idle_ready", if1.mem_ready_o, 1);
    check("inv_req", req1, 0);
    tick(5);
    mem1[16] <= 32'hE;
    mem1[17] <= 32'hF;
    tick(1);
    t = cyc;
    if1.mem_read_ready_i = 1;
    q1.push_back('{32'hE, 32'hF, t + 4});
    tick(1);
    if1.mem_read_ready_i = 0;
    drain(1);

    // simultaneous write and read to 0x60
    tick(1);
    t = cyc;
    if1.request_address_i = 32'h60;
    if1.write_data_i[0] = 32'h55;
    if1.write_data_i[1] = 32'h66;
    if1.mem_write_valid_i = 1;
    if1.mem_read_ready_i = 1;
    q1.push_back('{32'h55, 32'h66, t + 7});
    tick(1);
    if1.mem_write_valid_i = 0;
    check("wr_first_we", we1, 1);
    tick(2);
    check("wr_then_idle", if1.mem_ready_o, 1);
    tick(1);
    if1.mem_read_ready_i = 0;
    drain(1);

    // address wrap at 0x3FFC
    mem1[12'hFFF] <= 32'h77;
    mem1[0] <= 32'h88;
    tick(1);
    t = cyc;
    if1.request_address_i = 32'h3FFC;
    if1.mem_read_ready_i = 1;
    q1.push_back('{32'h77, 32'h88, t + 4});
    tick(1);
    if1.mem_read_ready_i = 0;
    check("wrap_addr0", addr1, 12'hFFF);
    tick(1);
    check("wrap_addr1", addr1, 12'h000);
    drain(1);

    // reset pulsed in RD_WAIT
    tick(1);
    if1.request_address_i = 32'h50;
    if1.mem_read_ready_i = 1;
    tick(1);
    if1.mem_read_ready_i = 0;
    tick(2);
    rst_n = 0;
    #1;
    check("mrst_valid", if1.mem_valid_o, 0);
    check("mrst_ready", if1.mem_ready_o, 0);
    check("mrst_req", req1, 0);
    check("mrst_we", we1, 0);
    check("mrst_addr", addr1, 0);
    check("mrst_wdata", wd1, 0);
    check("mrst_rd_w0", if1.read_data_o[0], 0);
    check("mrst_rd_w1", if1.read_data_o[1], 0);
    tick(2);
    rst_n = 1;
    tick(1);
    check("mrst_ready_after", if1.mem_ready_o, 1);
    tick(6);
    check("mrst_no_pending", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
